multi_channel_blinker: RTL and testbench
========================================

// Module: multi_channel_blinker
// PURPOSE
//  N-channel programmable LED blinker: shared beat prescaler, one rate register + down-timer + toggle per channel.
//  shift_left/shift_right adjust the rate of the channel picked by chan_sel.
//  Adds per-channel enable, global phase sync and selected-rate readback.
//  Sits between the debounced button front end and the LED pins.
// PARAMETERS
//  CHANNELS   4            number of independent blink channels (1..16)
//  PERIOD_W   9            rate/timer width; half-period = rate beats
//  BEAT_DIV   32           clocks per beat (>=2)
//  RESET_RATE 9'b000010000 per-channel rate value after reset; must be one-hot
//  CH_W = max(1,$clog2(CHANNELS)) is a localparam
// PORTS
//  clock        in   1         system clock, all state on posedge
//  reset        in   1         synchronous, active-high
//  chan_sel     in   CH_W      channel whose rate shift_left/shift_right modify; values >= CHANNELS ignored
//  shift_left   in   1         double selected rate (slower blink), one shift per asserted cycle
//  shift_right  in   1         halve selected rate (faster blink), one shift per asserted cycle
//  enable       in   CHANNELS  per-channel run enable
//  sync         in   1         single-cycle pulse: re-phase all channels
//  out          out  CHANNELS  blink outputs (registered)
//  beat         out  1         prescaler tick, 1 cycle wide
//  rate_sel     out  PERIOD_W  rate register of channel chan_sel (0 if chan_sel out of range)
// BEHAVIOUR
//  Reset: prescaler=0, beat=0, every rate=RESET_RATE, every timer=0, out=0.
//  Prescaler: counts 0..BEAT_DIV-1 and wraps; beat=1 in the cycle the count is BEAT_DIV-1.
//   First beat is in cycle BEAT_DIV after reset release. Free-running, unaffected by enable and sync.
//  Rate register (per channel, one-hot):
//   shift_left only: rate<<1, saturating; no change if MSB already set.
//   shift_right only: rate>>1, saturating; no change if rate==1.
//   Both or neither asserted: hold. Only channel chan_sel changes.
//   A rate change does not disturb the running timer; it takes effect at that channel's next reload.
//  Timer/out, per channel, evaluated in priority order:
//   1 reset
//   2 sync: timer<=0, out<=0 for all channels
//   3 enable[i]=0: timer<=0, out<=0
//   4 beat && timer==0: timer<=rate-1, out toggles (expire)
//   5 beat: timer<=timer-1
//   6 otherwise hold
//   First expire after enable rises or sync occurs is on the next beat.
//   Steady state: out toggles every rate beats; full period = 2*rate*BEAT_DIV clocks.
//   rate==1 gives a toggle on every beat.
//  Latency: out changes in the cycle after the beat cycle (registered). rate_sel is combinational from chan_sel.
//  Simultaneous cases:
//   sync + beat: sync wins, no toggle that beat.
//   enable fall + beat: out forced 0.
//   Shift on a channel in the same cycle it reloads: the reload uses the old rate.
// TESTING (bench uses BEAT_DIV=4, PERIOD_W=9, CHANNELS=4)
//  1 Reset, all enable=1, no shifts.
//    -> beat high every 4th clock, first in cycle 4.
//    -> out[0] toggles after the first beat, then every 16 beats; rate_sel=9'h010.
//  2 chan_sel=2, shift_right pulsed 4x.
//    -> rate_sel=9'h001; a 5th pulse leaves 9'h001.
//    -> out[2] toggles every beat; channels 0,1,3 unchanged.
//  3 chan_sel=1, shift_left pulsed 5x.
//    -> rate_sel=9'h100 (saturates at 9'h100).
//    -> out[1] half-period = 256 beats once the current count expires.
//  4 shift_left and shift_right asserted together for 3 cycles -> selected rate unchanged.
//  5 Mid-count, sync coincident with beat.
//    -> all out=0, no toggle that beat; all channels toggle together on the next beat.
//  6 enable[3] low for 10 beats, then high.
//    -> out[3]=0 throughout, toggles on the first beat after re-enable.
//    -> reset asserted mid-run returns all state to reset values in 1 cycle.

Source files
------------

// File: rtl/multi_channel_blinker.sv
// N-channel LED blinker: a shared beat prescaler plus, per channel, a one-hot rate,
// a down-timer and a toggle output. Rates are adjusted one channel at a time.
module multi_channel_blinker #(
  parameter int                  CHANNELS   = 4,
  parameter int                  PERIOD_W   = 9,
  parameter int                  BEAT_DIV   = 32,
  parameter logic [PERIOD_W-1:0] RESET_RATE = 9'b000010000,
  localparam int                 CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CH_W-1:0]     chan_sel,
  input  logic                shift_left,
  input  logic                shift_right,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync,
  output logic [CHANNELS-1:0] out,
  output logic                beat,
  output logic [PERIOD_W-1:0] rate_sel
);

  localparam int PS_W = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;

  logic [PS_W-1:0]     presc;
  logic [PERIOD_W-1:0] rate  [CHANNELS];
  logic [PERIOD_W-1:0] timer [CHANNELS];

  always_ff @(posedge clock) begin
    if (reset) begin
      presc <= '0;
    end else if (presc == PS_W'(BEAT_DIV - 1)) begin
      presc <= '0;
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

  // Decoded from the count, so beat is low while reset holds the count at zero.
  assign beat = (presc == PS_W'(BEAT_DIV - 1));

  always_ff @(posedge clock) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset) begin
        rate[i] <= RESET_RATE;
      end else if (32'(chan_sel) == 32'(i) && (shift_left ^ shift_right)) begin
        if (shift_left && !rate[i][PERIOD_W-1]) begin
          rate[i] <= rate[i] << 1;
        end else if (shift_right && rate[i] != PERIOD_W'(1)) begin
          rate[i] <= rate[i] >> 1;
        end
      end
    end
  end

  always_comb begin
    rate_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (32'(chan_sel) == 32'(i)) begin
        rate_sel = rate[i];
      end
    end
  end

  // The reload reads rate[i] before any same-cycle shift lands, so a shift
  // only affects the following half-period.
  always_ff @(posedge clock) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset || sync || !enable[i]) begin
        timer[i] <= '0;
        out[i]   <= 1'b0;
      end else if (beat && timer[i] == '0) begin
        timer[i] <= rate[i] - PERIOD_W'(1);
        out[i]   <= ~out[i];
      end else if (beat) begin
        timer[i] <= timer[i] - PERIOD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_blinker.sv
// Directed bench for multi_channel_blinker with a queue of expected values
// pushed ahead of stimulus and popped as the DUT responds.
module tb_multi_channel_blinker;

  localparam int CHANNELS = 4;
  localparam int PERIOD_W = 9;
  localparam int BEAT_DIV = 4;

  logic                clock = 1'b0;
  logic                reset;
  logic [1:0]          chan_sel;
  logic                shift_left;
  logic                shift_right;
  logic [CHANNELS-1:0] enable;
  logic                sync;
  logic [CHANNELS-1:0] out;
  logic                beat;
  logic [PERIOD_W-1:0] rate_sel;

  always #5 clock = ~clock;

  multi_channel_blinker #(
    .CHANNELS  (CHANNELS),
    .PERIOD_W  (PERIOD_W),
    .BEAT_DIV  (BEAT_DIV),
    .RESET_RATE(9'h010)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .chan_sel   (chan_sel),
    .shift_left (shift_left),
    .shift_right(shift_right),
    .enable     (enable),
    .sync       (sync),
    .out        (out),
    .beat       (beat),
    .rate_sel   (rate_sel)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL scoreboard_empty observed=%0h expected=none", obs);
      return;
    end
    e = sb.pop_front();
    compared++;
    assert (obs === e.val) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Returns just after the posedge that consumed a beat, so outputs show its effect.
  task automatic wait_beat();
    int n = 0;
    while (beat !== 1'b1 && n < 2 * BEAT_DIV) begin
      tick();
      n++;
    end
    if (beat !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL beat_timeout observed=0 expected=1");
    end
    tick();
  endtask

  task automatic do_sync();
    wait_beat();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    push("sync_clears_out", 32'h0);
    check(32'(out));
  endtask

  initial begin
    reset       = 1'b1;
    chan_sel    = 2'd0;
    shift_left  = 1'b0;
    shift_right = 1'b0;
    enable      = 4'hF;
    sync        = 1'b0;
    tick();
    tick();

    // 1: reset values, beat cadence, channel 0 at the default rate
    push("reset_out", 32'h0);
    push("reset_beat", 32'h0);
    push("reset_rate", 32'h010);
    check(32'(out));
    check(32'(beat));
    check(32'(rate_sel));
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      push($sformatf("first_beat_c%0d", c), (c == 3) ? 32'h1 : 32'h0);
      tick();
      check(32'(beat));
    end
    tick();
    push("first_toggle_out", 32'hF);
    push("after_first_beat", 32'h0);
    check(32'(out));
    check(32'(beat));
    for (int c = 1; c <= 8; c++) begin
      push($sformatf("beat_cadence_c%0d", c), (c % 4 == 3) ? 32'h1 : 32'h0);
      tick();
      check(32'(beat));
    end
    for (int b = 4; b <= 16; b++) wait_beat();
    push("ch0_hold_beat16", 32'hF);
    check(32'(out));
    wait_beat();
    push("ch0_toggle_beat17", 32'h0);
    check(32'(out));

    // 2: channel 2 shifted right down to rate 1
    chan_sel = 2'd2;
    push("rsh_1", 32'h008);
    push("rsh_2", 32'h004);
    push("rsh_3", 32'h002);
    push("rsh_4", 32'h001);
    push("rsh_sat", 32'h001);
    for (int p = 0; p < 5; p++) begin
      shift_right = 1'b1;
      tick();
      shift_right = 1'b0;
      check(32'(rate_sel));
    end
    chan_sel = 2'd0;
    #1;
    push("ch0_rate_untouched", 32'h010);
    check(32'(rate_sel));
    chan_sel = 2'd3;
    #1;
    push("ch3_rate_untouched", 32'h010);
    check(32'(rate_sel));
    do_sync();
    for (int k = 1; k <= 5; k++) begin
      push($sformatf("fast_ch2_k%0d", k), (k % 2 == 1) ? 32'hF : 32'hB);
      wait_beat();
      check(32'(out));
    end

    // 3: channel 1 shifted left to saturation, then a 256-beat half-period
    chan_sel = 2'd1;
    push("lsh_1", 32'h020);
    push("lsh_2", 32'h040);
    push("lsh_3", 32'h080);
    push("lsh_4", 32'h100);
    push("lsh_sat", 32'h100);
    for (int p = 0; p < 5; p++) begin
      shift_left = 1'b1;
      tick();
      shift_left = 1'b0;
      check(32'(rate_sel));
    end
    do_sync();
    for (int k = 1; k <= 257; k++) begin
      wait_beat();
      if (k == 1) begin
        push("slow_k1", 32'hF);
        check(32'(out));
      end else if (k == 17) begin
        push("slow_k17", 32'h6);
        check(32'(out));
      end else if (k == 256) begin
        push("slow_k256", 32'h2);
        check(32'(out));
      end else if (k == 257) begin
        push("slow_k257", 32'hD);
        check(32'(out));
      end
    end

    // 4: both shift inputs together hold the rate
    shift_left  = 1'b1;
    shift_right = 1'b1;
    for (int c = 0; c < 3; c++) begin
      push($sformatf("both_hold_c%0d", c), 32'h100);
      tick();
      check(32'(rate_sel));
    end
    chan_sel = 2'd0;
    tick();
    shift_left  = 1'b0;
    shift_right = 1'b0;
    push("both_hold_ch0", 32'h010);
    check(32'(rate_sel));

    // 5: sync landing on a beat
    wait_beat();
    tick();
    tick();
    tick();
    push("beat_before_sync", 32'h1);
    check(32'(beat));
    sync = 1'b1;
    tick();
    sync = 1'b0;
    push("sync_on_beat_out", 32'h0);
    check(32'(out));
    wait_beat();
    push("post_sync_k1", 32'hF);
    check(32'(out));
    wait_beat();
    push("post_sync_k2", 32'hB);
    check(32'(out));

    // 6: channel 3 disabled for 10 beats, then re-enabled
    enable = 4'b0111;
    tick();
    push("disable_ch3_now", 32'h3);
    check(32'(out));
    for (int k = 3; k <= 12; k++) begin
      push($sformatf("ch3_off_k%0d", k), (k % 2 == 1) ? 32'h7 : 32'h3);
      wait_beat();
      check(32'(out));
    end
    enable = 4'hF;
    push("reenable_k13", 32'hF);
    push("reenable_k14", 32'hB);
    wait_beat();
    check(32'(out));
    wait_beat();
    check(32'(out));

    // mid-run reset
    chan_sel = 2'd2;
    tick();
    tick();
    reset = 1'b1;
    tick();
    push("mid_reset_out", 32'h0);
    push("mid_reset_beat", 32'h0);
    push("mid_reset_rate", 32'h010);
    check(32'(out));
    check(32'(beat));
    check(32'(rate_sel));
    reset = 1'b0;
    tick();
    tick();
    tick();
    push("mid_reset_first_beat", 32'h1);
    check(32'(beat));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
